inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 94 +++++++++
 tb/tb_inst_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: buffers one-hot mnemonic requests and writes encoded words to sequential instruction memory
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_load,
  input  logic [7:0]  start_addr_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_onehot,
  input  logic [3:0]  operand_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_addr,
  output logic [7:0]  out_data,
  output logic        err_pulse,
  output logic [7:0]  illegal_cnt,
  output logic        done,
  output logic        wrapped
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [7:0]  r_addr, r_cnt;
  logic        r_err, r_wrap;
  logic        w_empty, w_full, w_legal, w_accept, w_push, w_pop, w_end, w_start;
  logic [3:0]  w_idx;
  logic [7:0]  w_word;
  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_legal  = (op_onehot != '0) && ((op_onehot & (op_onehot - 16'd1)) == '0);
  assign in_ready = (r_state == RUN) && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && out_ready;
  assign w_word   = {w_idx, operand_in};
  assign w_end    = w_push && (w_word == 8'h0F);
  assign w_start  = start_load && (r_state == IDLE || r_state == DONE);
  assign out_valid   = !w_empty;
  assign out_data    = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
  assign out_addr    = r_addr;
  assign err_pulse   = r_err;
  assign illegal_cnt = r_cnt;
  assign done        = r_state == DONE;
  assign wrapped     = r_wrap;
  // opcode is the position of the set bit; only meaningful when the select is legal
  always_comb begin
    w_idx = '0;
    for (int k = 0; k < 16; k++) if (op_onehot[k]) w_idx = 4'(k);
  end
  // load sequencing: start from idle/done, stop accepting at the end marker, finish once drained
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = RUN;
    else if (r_state == RUN && w_end) w_next = DRAIN;
    else if (r_state == DRAIN && w_empty) w_next = DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // FIFO pointers, write address, error and wrap bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_addr <= r_addr + 8'd1;
        if (r_addr == 8'hFF) r_wrap <= 1'b1;
      end
      if (w_start) begin
        r_addr <= start_addr_in;
        r_wrap <= 1'b0;
      end
    end
  end
  // buffer storage; stale entries are unreachable once pointers reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_word;
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and random stimulus against a queue-based reference of the encoder
module tb_inst_encoder;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        reset, start_load, in_valid, out_ready;
  logic [7:0]  start_addr_in;
  logic [15:0] op_onehot;
  logic [3:0]  operand_in;
  logic        in_ready, out_valid, err_pulse, done, wrapped;
  logic [7:0]  out_addr, out_data, illegal_cnt;
  int          n_chk = 0, n_err = 0;
  int          m_mode = 0, m_addr = 0, m_cnt = 0;
  logic        m_err = 1'b0, m_wrap = 1'b0;
  logic [7:0]  m_q[$];

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_addr_in(start_addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .op_onehot(op_onehot), .operand_in(operand_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .err_pulse(err_pulse), .illegal_cnt(illegal_cnt), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    int pm, sz;
    logic acc, pop, legal;
    logic [7:0] w;
    pm = m_mode;
    sz = m_q.size();
    if (reset) begin
      m_mode = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_wrap = 0; m_q = {};
    end else begin
      acc   = in_valid && pm == 1 && sz < DEPTH;
      pop   = sz > 0 && out_ready;
      legal = $countones(op_onehot) == 1;
      m_err = acc && !legal;
      if (m_err && m_cnt < 255) m_cnt++;
      if (pop) begin
        void'(m_q.pop_front());
        if (m_addr == 255) m_wrap = 1;
        m_addr = (m_addr + 1) % 256;
      end
      if (acc && legal) begin
        w = {4'($clog2(op_onehot)), operand_in};
        m_q.push_back(w);
        if (w == 8'h0F) m_mode = 2;
      end else if (pm == 2 && sz == 0) m_mode = 3;
      if ((pm == 0 || pm == 3) && start_load) begin
        m_mode = 1; m_addr = start_addr_in; m_wrap = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, m_mode == 1 && m_q.size() < DEPTH);
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("out_data", out_data, m_q.size() > 0 ? m_q[0] : 8'h00);
    chk("out_addr", out_addr, m_addr);
    chk("err_pulse", err_pulse, m_err);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    chk("done", done, m_mode == 3);
    chk("wrapped", wrapped, m_wrap);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [15:0] op, input logic [3:0] opnd);
    in_valid = 1; op_onehot = op; operand_in = opnd;
    cycle();
    in_valid = 0; op_onehot = '0; operand_in = '0;
  endtask

  task automatic load(input logic [7:0] a);
    start_load = 1; start_addr_in = a;
    cycle();
    start_load = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) cycle();
    chk("done_reached", done, 1);
  endtask

  initial begin
    reset = 1; start_load = 0; start_addr_in = '0; in_valid = 0;
    op_onehot = '0; operand_in = '0; out_ready = 0;
    idle(2);
    reset = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_in_ready", in_ready, 0);
    // basic writes with an always-ready sink
    out_ready = 1;
    load(8'h10);
    send(16'h0002, 4'h3);
    chk("w1_data", out_data, 8'h13);
    chk("w1_addr", out_addr, 8'h10);
    send(16'h8000, 4'h5);
    chk("w2_data", out_data, 8'hF5);
    chk("w2_addr", out_addr, 8'h11);
    idle(1);
    // illegal selects
    send(16'h0000, 4'h1);
    chk("err1", err_pulse, 1);
    idle(1);
    chk("err1_clear", err_pulse, 0);
    send(16'h0006, 4'h2);
    chk("err2", err_pulse, 1);
    chk("cnt2", illegal_cnt, 2);
    chk("no_write", out_valid, 0);
    // fill with a stalled sink
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) send(16'h0010 << i, 4'(i));
    chk("full_ready", in_ready, 0);
    idle(2);
    chk("hold_data", out_data, 8'h40);
    chk("hold_addr", out_addr, 8'h12);
    out_ready = 1;
    idle(DEPTH);
    chk("drained_addr", out_addr, 8'h16);
    send(16'h0001, 4'hF);
    wait_done();
    // address wrap
    load(8'hFE);
    for (int i = 0; i < 3; i++) send(16'h0020, 4'(i));
    idle(2);
    chk("wrapped", wrapped, 1);
    chk("wrap_addr", out_addr, 8'h01);
    // end marker
    send(16'h1000, 4'h2);
    chk("beq_data", out_data, 8'hC2);
    send(16'h0001, 4'hF);
    chk("end_data", out_data, 8'h0F);
    chk("end_ready", in_ready, 0);
    wait_done();
    load(8'h40);
    chk("reload_done", done, 0);
    chk("reload_ready", in_ready, 1);
    // reset discards buffered words
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(16'h0100, 4'(i));
    chk("buffered", out_valid, 1);
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_flush", out_valid, 0);
    out_ready = 1;
    idle(3);
    chk("rst_no_write", out_valid, 0);
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      reset         = $urandom_range(0, 149) == 0;
      start_load    = $urandom_range(0, 19) == 0;
      start_addr_in = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      in_valid      = $urandom_range(0, 1);
      out_ready     = $urandom_range(0, 9) < 6;
      operand_in    = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       op_onehot = '0;
        1:       op_onehot = 16'($urandom);
        2:       begin op_onehot = 16'h0001; operand_in = 4'hF; end
        default: op_onehot = 16'h0001 << $urandom_range(0, 15);
      endcase
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
